// File: rtl/csr_pkg.sv
// Shared CSR addresses, bit positions and the address decoder for csr_unit.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIX_MT       = 7;

  localparam logic [31:0] CAUSE_M_TIMER = 32'h8000_0007;

  // Offset added to the trap base in vectored mode (cause 7 * 4 bytes).
  localparam int VEC_TIMER_OFFSET = 28;

  typedef enum logic [3:0] {
    SEL_NONE,
    SEL_MSTATUS,
    SEL_MIE,
    SEL_MTVEC,
    SEL_MEPC,
    SEL_MCAUSE,
    SEL_MIP,
    SEL_MCYCLE,
    SEL_MCYCLEH,
    SEL_MINSTRET,
    SEL_MINSTRETH
  } csr_sel_e;

  function automatic csr_sel_e decode_addr(input logic [11:0] addr);
    csr_sel_e sel;
    case (addr)
      CSR_MSTATUS:   sel = SEL_MSTATUS;
      CSR_MIE:       sel = SEL_MIE;
      CSR_MTVEC:     sel = SEL_MTVEC;
      CSR_MEPC:      sel = SEL_MEPC;
      CSR_MCAUSE:    sel = SEL_MCAUSE;
      CSR_MIP:       sel = SEL_MIP;
      CSR_MCYCLE:    sel = SEL_MCYCLE;
      CSR_MCYCLEH:   sel = SEL_MCYCLEH;
      CSR_MINSTRET:  sel = SEL_MINSTRET;
      CSR_MINSTRETH: sel = SEL_MINSTRETH;
      default:       sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/csr_unit_if.sv
// Decoder/datapath <-> CSR unit bundle. The datapath is the master.
interface csr_unit_if #(parameter int XLEN = 32);
  logic [XLEN-1:0] pc;
  logic            instr_valid;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic            csr_rd;
  logic            csr_wr;
  logic            is_mret;
  logic            timer_irq;
  logic [XLEN-1:0] csr_rdata;
  logic            epc_taken;
  logic [XLEN-1:0] epc;
  logic            csr_illegal;

  modport master (
    output pc, instr_valid, csr_addr, csr_wdata, csr_rd, csr_wr, is_mret, timer_irq,
    input  csr_rdata, epc_taken, epc, csr_illegal
  );

  modport slave (
    input  pc, instr_valid, csr_addr, csr_wdata, csr_rd, csr_wr, is_mret, timer_irq,
    output csr_rdata, epc_taken, epc, csr_illegal
  );
endinterface

// File: rtl/csr_counter64.sv
// Two-word free-running counter; a write to either half freezes the whole
// counter for that cycle so the written value is held exactly.
module csr_counter64 #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           inc,
  input  logic           wr_lo,
  input  logic           wr_hi,
  input  logic [W-1:0]   wdata,
  output logic [2*W-1:0] out
);

  // Counter update: reset, half-word replace, or increment with natural wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      out <= '0;
    end else if (wr_lo || wr_hi) begin
      if (wr_lo) out[W-1:0]   <= wdata;
      if (wr_hi) out[2*W-1:W] <= wdata;
    end else if (inc) begin
      out <= out + 1'b1;
    end
  end

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file with timer-interrupt trap entry and MRET return.
module csr_unit
  import csr_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
  input  logic       clk,
  input  logic       rst,
  csr_unit_if.slave  bus
);

  localparam logic [XLEN-1:0] MTVEC_MASK = ~XLEN'(2);
  localparam logic [XLEN-1:0] MEPC_MASK  = ~XLEN'(3);

  csr_sel_e        sel;
  logic            impl;
  logic            irq_take;
  logic            mret_take;
  logic            wr_en;

  logic            st_mie;
  logic            st_mpie;
  logic            mtie;
  logic            mtip;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] mcause;

  logic [2*XLEN-1:0] mcycle;
  logic [2*XLEN-1:0] minstret;

  logic [XLEN-1:0] mstatus_val;
  logic [XLEN-1:0] mie_val;
  logic [XLEN-1:0] mip_val;
  logic [XLEN-1:0] trap_base;
  logic [XLEN-1:0] trap_target;

  // Address decode, trap/return qualification and write gating.
  always_comb begin
    sel       = decode_addr(bus.csr_addr);
    impl      = (sel != SEL_NONE);
    irq_take  = st_mie & mtie & mtip & bus.instr_valid;
    mret_take = bus.is_mret & bus.instr_valid & ~irq_take;
    // A trapped instruction re-executes later, so its write must not land.
    wr_en     = bus.csr_wr & impl & ~irq_take & ~mret_take;
  end

  // Architectural views of the packed status/enable/pending registers.
  always_comb begin
    mstatus_val               = '0;
    mstatus_val[MSTATUS_MIE]  = st_mie;
    mstatus_val[MSTATUS_MPIE] = st_mpie;
    mie_val                   = '0;
    mie_val[MIX_MT]           = mtie;
    mip_val                   = '0;
    mip_val[MIX_MT]           = mtip;
  end

  // Combinational read port and illegal-address flag.
  always_comb begin
    bus.csr_rdata   = '0;
    bus.csr_illegal = (bus.csr_rd | bus.csr_wr) & ~impl;
    if (bus.csr_rd) begin
      case (sel)
        SEL_MSTATUS:   bus.csr_rdata = mstatus_val;
        SEL_MIE:       bus.csr_rdata = mie_val;
        SEL_MTVEC:     bus.csr_rdata = mtvec;
        SEL_MEPC:      bus.csr_rdata = mepc;
        SEL_MCAUSE:    bus.csr_rdata = mcause;
        SEL_MIP:       bus.csr_rdata = mip_val;
        SEL_MCYCLE:    bus.csr_rdata = mcycle[XLEN-1:0];
        SEL_MCYCLEH:   bus.csr_rdata = mcycle[2*XLEN-1:XLEN];
        SEL_MINSTRET:  bus.csr_rdata = minstret[XLEN-1:0];
        SEL_MINSTRETH: bus.csr_rdata = minstret[2*XLEN-1:XLEN];
        default:       bus.csr_rdata = '0;
      endcase
    end
  end

  // PC redirect: trap vector on interrupt, mepc on MRET, held off in reset.
  always_comb begin
    trap_base   = mtvec & ~XLEN'(3);
    trap_target = mtvec[0] ? trap_base + XLEN'(VEC_TIMER_OFFSET) : trap_base;
    bus.epc_taken = ~rst & (irq_take | mret_take);
    bus.epc       = '0;
    if (bus.epc_taken) begin
      bus.epc = irq_take ? trap_target : mepc;
    end
  end

  // Trap CSR state: reset, trap entry, MRET, then ordinary CSR writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_mie  <= 1'b0;
      st_mpie <= 1'b0;
      mtie    <= 1'b0;
      mtip    <= 1'b0;
      mtvec   <= MTVEC_RESET & MTVEC_MASK;
      mepc    <= '0;
      mcause  <= '0;
    end else begin
      mtip <= bus.timer_irq;
      if (irq_take) begin
        mepc    <= bus.pc & MEPC_MASK;
        mcause  <= XLEN'(CAUSE_M_TIMER);
        st_mpie <= st_mie;
        st_mie  <= 1'b0;
      end else if (mret_take) begin
        st_mie  <= st_mpie;
        st_mpie <= 1'b1;
      end else if (wr_en) begin
        case (sel)
          SEL_MSTATUS: begin
            st_mie  <= bus.csr_wdata[MSTATUS_MIE];
            st_mpie <= bus.csr_wdata[MSTATUS_MPIE];
          end
          SEL_MIE:    mtie   <= bus.csr_wdata[MIX_MT];
          SEL_MTVEC:  mtvec  <= bus.csr_wdata & MTVEC_MASK;
          SEL_MEPC:   mepc   <= bus.csr_wdata & MEPC_MASK;
          SEL_MCAUSE: mcause <= bus.csr_wdata;
          default: ;
        endcase
      end
    end
  end

  csr_counter64 #(.W(XLEN)) u_mcycle (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .wr_lo (wr_en && sel == SEL_MCYCLE),
    .wr_hi (wr_en && sel == SEL_MCYCLEH),
    .wdata (bus.csr_wdata),
    .out   (mcycle)
  );

  csr_counter64 #(.W(XLEN)) u_minstret (
    .clk   (clk),
    .rst   (rst),
    .inc   (bus.instr_valid & ~irq_take),
    .wr_lo (wr_en && sel == SEL_MINSTRET),
    .wr_hi (wr_en && sel == SEL_MINSTRETH),
    .wdata (bus.csr_wdata),
    .out   (minstret)
  );

endmodule

// File: doc/csr_unit.md
Name: csr_unit

Overview:
- Machine-mode CSR register file and trap unit.
- Acts as the responder to the decoder's csr_rd/csr_wr/is_CSR strobes.
- Holds the trap CSRs and the cycle and instret counters.
- Takes timer interrupts and executes MRET, driving a PC redirect (epc_taken/epc) back to the fetch stage.
- Sits beside the register file in the single-cycle datapath; wb_sel=2'b11 selects its rdata.

Parameters:
- XLEN, 32, data width.
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- pc  input  XLEN  PC of the instruction in flight
- instr_valid  input  1  the instruction in flight retires this cycle unless trapped
- csr_addr  input  12  inst[31:20]
- csr_wdata  input  XLEN  rs1 value (CSRRW source)
- csr_rd  input  1  read strobe from the decoder
- csr_wr  input  1  write strobe from the decoder
- is_mret  input  1  instruction is MRET
- timer_irq  input  1  level-sensitive machine timer interrupt
- csr_rdata  output  XLEN  read data to writeback
- epc_taken  output  1  redirect PC this cycle
- epc  output  XLEN  redirect target
- csr_illegal  output  1  csr_rd or csr_wr asserted to an unimplemented address

Behaviour:
- Reads are combinational.
  - csr_rdata = selected CSR value when csr_rd=1, else 0.
  - An unimplemented address returns 0 and raises csr_illegal (combinational).
- Writes commit on the rising clk edge when csr_wr=1, the address is implemented, and no trap is taken that cycle.
  - For CSRRW the old value is read and the new value is written in the same cycle.
- Implemented CSRs, read/write masks and reset values:
  - mstatus 0x300: only MIE[3] and MPIE[7] are writable; all other bits read 0.
  - mie 0x304: only MTIE[7] is writable.
  - mtvec 0x305: bit 1 is forced to 0; MODE = bit 0 (0 = direct, 1 = vectored). Reset = MTVEC_RESET.
  - mepc 0x341: bits [1:0] are forced to 0.
  - mcause 0x342: full 32-bit write.
  - mip 0x344: read-only. MTIP[7] is a register loaded with timer_irq every cycle (1-cycle latency). Writes are ignored with no illegal flag.
  - mcycle/mcycleh 0xB00/0xB80 and minstret/minstreth 0xB02/0xB82: 64-bit counters.
  - All CSRs other than mtvec reset to 0.
- Counters:
  - mcycle increments every cycle after reset.
  - minstret increments when instr_valid=1 and no trap is taken.
  - A write to either half replaces that half. The increment is suppressed that cycle for the whole 64-bit counter, so the written value holds exactly.
  - Low half 32'hFFFF_FFFF carries into the high half. 64-bit all-ones wraps to 0.
- Interrupt condition: irq_take = mstatus.MIE & mie.MTIE & mip.MTIP & instr_valid.
- When irq_take=1:
  - Combinational redirect: epc_taken=1, epc = {mtvec[31:2],2'b00}, plus 28 if MODE=1.
  - At the clock edge: mepc<=pc, mcause<=32'h8000_0007, MPIE<=MIE, MIE<=0.
  - The CSR write and minstret increment of the trapped instruction are suppressed; the instruction re-executes after MRET.
- MRET (is_mret=1, instr_valid=1, no irq_take):
  - epc_taken=1, epc=mepc.
  - At the edge: MIE<=MPIE, MPIE<=1.
- Priority: irq_take over MRET over CSR write.
- When epc_taken=0, epc=0.
- rst asserted mid-operation: every register returns to its reset value at that edge. While rst=1, epc_taken=0 regardless of inputs.
- A trap and a CSR write to mstatus in the same cycle resolve as trap only.

Decomposition:
- Package csr_pkg holds:
  - 12-bit address localparams: CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MEPC, CSR_MCAUSE, CSR_MIP, CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH.
  - Bit indices: MSTATUS_MIE=3, MSTATUS_MPIE=7, MIX_MT=7.
  - Cause constant: CAUSE_M_TIMER=32'h8000_0007.
- One sub-module, csr_counter64:
  - Ports: clk, rst, inc, wr_lo, wr_hi, wdata, out[63:0].
  - Instantiated twice, for mcycle and minstret.

Test Plan:
- Reset, then read mstatus, mtvec and mcause -> csr_rdata=0. Read 0x7C0 -> csr_rdata=0, csr_illegal=1.
- Write mtvec=32'h0000_0100 (MODE 0), mie=32'h80, mstatus=32'h8. Raise timer_irq. Next cycle with pc=32'h40, instr_valid=1 -> epc_taken=1, epc=32'h100. After the edge: mepc=32'h40, mcause=32'h8000_0007, mstatus=32'h80.
- Same setup with mtvec=32'h0000_0101 -> epc=32'h11C.
- After the trap, assert is_mret with instr_valid=1 -> epc=32'h40, epc_taken=1. After the edge mstatus=32'h88.
- Write mcycle=32'hFFFF_FFFF, then idle 2 cycles -> mcycleh=1, mcycle=32'h1. Write mcycleh=5 -> the next read of mcycleh is 5 and the low half is unchanged that cycle.
- csr_wr to mstatus in the same cycle an interrupt is taken -> write discarded, mstatus=32'h80, minstret not incremented.
